// File: rtl/rtable_env_if.sv
// rtl/rtable_env_if.sv - request/response and override-write bundle for rtable_env
// master drives requests and override writes; slave is the reward unit.

interface rtable_env_if #(
   parameter int ROW_BITS   = 3,
   parameter int COL_BITS   = 3,
   parameter int DATA_WIDTH = 8
);
   localparam int ADDR_W = ROW_BITS + COL_BITS + 2;

   logic                  i_req_valid;
   logic                  o_req_ready;
   logic [ADDR_W-1:0]     i_req_addr;
   logic                  o_rsp_valid;
   logic                  i_rsp_ready;
   logic [DATA_WIDTH-1:0] o_reward;
   logic [ROW_BITS-1:0]   o_next_row;
   logic [COL_BITS-1:0]   o_next_col;
   logic                  o_wall;
   logic                  o_terminal;
   logic                  i_wr_en;
   logic                  i_wr_clr;
   logic [ADDR_W-1:0]     i_wr_addr;
   logic [DATA_WIDTH-1:0] i_wr_data;

   modport master (
      output i_req_valid, i_req_addr, i_rsp_ready, i_wr_en, i_wr_clr, i_wr_addr, i_wr_data,
      input  o_req_ready, o_rsp_valid, o_reward, o_next_row, o_next_col, o_wall, o_terminal
   );

   modport slave (
      input  i_req_valid, i_req_addr, i_rsp_ready, i_wr_en, i_wr_clr, i_wr_addr, i_wr_data,
      output o_req_ready, o_rsp_valid, o_reward, o_next_row, o_next_col, o_wall, o_terminal
   );
endinterface

// File: rtl/rtable_env.sv
// rtl/rtable_env.sv - grid-world reward/next-state unit, 2-stage pipe with override table
// Optional macro RTABLE_STEP_PENALTY_EN: plain moves return -STEP_PENALTY instead of 0.

module rtable_env #(
   parameter int ROW_BITS     = 3,
   parameter int COL_BITS     = 3,
   parameter int DATA_WIDTH   = 8,
   parameter int GOAL_ROW     = 7,
   parameter int GOAL_COL     = 7,
   parameter int WALL_REWARD  = -127,
   parameter int GOAL_REWARD  = 127,
   parameter int STEP_PENALTY = 1
) (
   input logic         i_clk,
   input logic         i_rst_n,
   rtable_env_if.slave bus
);
   localparam int ADDR_W = ROW_BITS + COL_BITS + 2;
   localparam int DEPTH  = 2 ** ADDR_W;

`ifdef RTABLE_STEP_PENALTY_EN
   localparam int STEP_SCALE = 1;
`else
   localparam int STEP_SCALE = 0;
`endif
   localparam int STEP_REWARD = -(STEP_SCALE * STEP_PENALTY);

   localparam logic [DATA_WIDTH-1:0] WALL_R     = WALL_REWARD[DATA_WIDTH-1:0];
   localparam logic [DATA_WIDTH-1:0] GOAL_R     = GOAL_REWARD[DATA_WIDTH-1:0];
   localparam logic [DATA_WIDTH-1:0] STEP_R     = STEP_REWARD[DATA_WIDTH-1:0];
   localparam logic [ROW_BITS-1:0]   GOAL_ROW_V = GOAL_ROW[ROW_BITS-1:0];
   localparam logic [COL_BITS-1:0]   GOAL_COL_V = GOAL_COL[COL_BITS-1:0];

   logic [DEPTH-1:0]      ov_valid_q, ov_valid_d;
   logic [DATA_WIDTH-1:0] ov_mem_q [DEPTH];

   logic                  s1_valid_q, s1_valid_d;
   logic [ADDR_W-1:0]     s1_addr_q, s1_addr_d;
   logic                  s1_hit_q, s1_hit_d;
   logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] reward_q, reward_d;
   logic [ROW_BITS-1:0]   next_row_q, next_row_d;
   logic [COL_BITS-1:0]   next_col_q, next_col_d;
   logic                  wall_q, wall_d;
   logic                  term_q, term_d;

   logic                  advance, accept, wall, goal;
   logic [ROW_BITS-1:0]   cur_row, nxt_row;
   logic [COL_BITS-1:0]   cur_col, nxt_col;
   logic [DATA_WIDTH-1:0] reward;

   assign advance = !rsp_valid_q || bus.i_rsp_ready;
   assign accept  = bus.i_req_valid && advance;

   always_comb begin
      ov_valid_d = ov_valid_q;
      if (bus.i_wr_en) ov_valid_d[bus.i_wr_addr] = !bus.i_wr_clr;
   end

   // Data array carries no reset; only the valid bits define table contents.
   always_ff @(posedge i_clk) begin
      if (bus.i_wr_en && !bus.i_wr_clr) ov_mem_q[bus.i_wr_addr] <= bus.i_wr_data;
   end

   // S1 captures the RAM word once at acceptance and holds it through stalls.
   always_comb begin
      s1_valid_d = advance ? bus.i_req_valid : s1_valid_q;
      s1_addr_d  = accept ? bus.i_req_addr : s1_addr_q;
      s1_hit_d   = accept ? ov_valid_q[bus.i_req_addr] : s1_hit_q;
      s1_data_d  = accept ? ov_mem_q[bus.i_req_addr] : s1_data_q;
   end

   always_comb begin
      cur_row = s1_addr_q[ADDR_W-1 -: ROW_BITS];
      cur_col = s1_addr_q[2 +: COL_BITS];
      nxt_row = cur_row;
      nxt_col = cur_col;
      wall    = 1'b0;
      case (s1_addr_q[1:0])
         2'b00:   if (cur_col == '0) wall = 1'b1; else nxt_col = cur_col - COL_BITS'(1);
         2'b01:   if (cur_row == '0) wall = 1'b1; else nxt_row = cur_row - ROW_BITS'(1);
         2'b10:   if (cur_col == '1) wall = 1'b1; else nxt_col = cur_col + COL_BITS'(1);
         default: if (cur_row == '1) wall = 1'b1; else nxt_row = cur_row + ROW_BITS'(1);
      endcase
      goal = (nxt_row == GOAL_ROW_V) && (nxt_col == GOAL_COL_V);
      if (s1_hit_q)  reward = s1_data_q;
      else if (wall) reward = WALL_R;
      else if (goal) reward = GOAL_R;
      else           reward = STEP_R;
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      reward_d    = reward_q;
      next_row_d  = next_row_q;
      next_col_d  = next_col_q;
      wall_d      = wall_q;
      term_d      = term_q;
      if (advance) begin
         rsp_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            reward_d   = reward;
            next_row_d = nxt_row;
            next_col_d = nxt_col;
            wall_d     = wall;
            term_d     = goal;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ov_valid_q  <= '0;
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         s1_hit_q    <= 1'b0;
         s1_data_q   <= '0;
         rsp_valid_q <= 1'b0;
         reward_q    <= '0;
         next_row_q  <= '0;
         next_col_q  <= '0;
         wall_q      <= 1'b0;
         term_q      <= 1'b0;
      end else begin
         ov_valid_q  <= ov_valid_d;
         s1_valid_q  <= s1_valid_d;
         s1_addr_q   <= s1_addr_d;
         s1_hit_q    <= s1_hit_d;
         s1_data_q   <= s1_data_d;
         rsp_valid_q <= rsp_valid_d;
         reward_q    <= reward_d;
         next_row_q  <= next_row_d;
         next_col_q  <= next_col_d;
         wall_q      <= wall_d;
         term_q      <= term_d;
      end
   end

   assign bus.o_req_ready = advance;
   assign bus.o_rsp_valid = rsp_valid_q;
   assign bus.o_reward    = reward_q;
   assign bus.o_next_row  = next_row_q;
   assign bus.o_next_col  = next_col_q;
   assign bus.o_wall      = wall_q;
   assign bus.o_terminal  = term_q;
endmodule
